// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants and types for the SM83 bus arbiter and OAM DMA engine.
// Imported by oam_dma_arbiter.
package oam_dma_arbiter_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
  localparam int          OAM_DMA_LEN  = 160;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  typedef enum logic [1:0] {
    RT_DMA_REG,
    RT_IO,
    RT_BUS
  } route_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// SM83 external bus owner: shares the bus between CPU and OAM DMA,
// and hosts the DMA source register at 0xFF46.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          OAM_LEN     = OAM_DMA_LEN,
  parameter logic [7:0]  BLOCK_RDATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        dma_active
);

  localparam logic [7:0] LEN8 = 8'(OAM_LEN);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] dma_reg_q, dma_reg_d;

  logic       dma_wr;
  logic       rd_req;
  logic       acc;
  logic       xfer;
  logic [7:0] src_hi;
  route_t     route;

  function automatic route_t decode(input logic [15:0] a);
    route_t r;
    if (a == DMA_REG_ADDR) r = RT_DMA_REG;
    else if (a[15:8] == HIGH_PAGE) r = RT_IO;
    else r = RT_BUS;
    return r;
  endfunction

  // Echo RAM pages E0-FF fold back onto C0-DF.
  function automatic logic [7:0] src_page(input logic [7:0] r);
    return (r >= 8'hE0) ? (r - 8'h20) : r;
  endfunction

  assign route  = decode(cpu_addr);
  assign dma_wr = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign rd_req = cpu_rd && !cpu_wr;
  assign acc    = rd_req || cpu_wr;
  assign xfer   = (state_q == DMA_XFER);
  assign src_hi = src_page(dma_reg_q);

  assign dma_active = (state_q != DMA_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DMA_IDLE;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      dma_reg_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      dma_reg_q <= dma_reg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    dma_reg_d = dma_reg_q;
    if (tick) begin
      case (state_q)
        DMA_START: begin
          state_d = DMA_XFER;
          idx_d   = 8'h00;
        end
        DMA_XFER: begin
          if (idx_q < LEN8) data_d = bus_rdata;
          if (idx_q == LEN8) begin
            state_d = DMA_IDLE;
            idx_d   = 8'h00;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        default: ;
      endcase
      // A new source write restarts from any state.
      if (dma_wr) begin
        dma_reg_d = cpu_wdata;
        idx_d     = 8'h00;
        state_d   = DMA_START;
      end
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    io_addr   = 8'h00;
    io_wdata  = 8'h00;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    oam_addr  = 8'h00;
    oam_wdata = 8'h00;
    oam_wr    = 1'b0;

    unique case (1'b1)
      (route == RT_DMA_REG): begin
        cpu_rdata = dma_reg_q;
      end
      (route == RT_IO): begin
        io_addr   = acc ? cpu_addr[7:0] : 8'h00;
        io_wdata  = cpu_wr ? cpu_wdata : 8'h00;
        io_rd     = rd_req;
        io_wr     = cpu_wr;
        cpu_rdata = io_rdata;
      end
      default: begin
        if (!xfer) begin
          bus_addr  = acc ? cpu_addr : 16'h0000;
          bus_wdata = cpu_wr ? cpu_wdata : 8'h00;
          bus_rd    = rd_req;
          bus_wr    = cpu_wr;
          cpu_rdata = bus_rdata;
        end else begin
          cpu_rdata = BLOCK_RDATA;
        end
      end
    endcase

    // Read of byte n overlaps the OAM write of byte n-1.
    if (xfer) begin
      if (idx_q < LEN8) begin
        bus_rd   = 1'b1;
        bus_addr = {src_hi, idx_q};
      end
      if (idx_q != 8'h00) begin
        oam_wr    = 1'b1;
        oam_addr  = idx_q - 8'd1;
        oam_wdata = data_q;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: DMA reads and OAM writes are
// queued on stimulus and popped when the DUT strobes them.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wr;
  logic        dma_active;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int tick_div = 1;
  int act_ticks = 0;
  int act_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [15:0] rdq[$];
  logic [15:0] oamq[$];
  logic [7:0]  oam_m[256];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  assign bus_rdata = mem_val(bus_addr);
  assign io_rdata  = io_addr ^ 8'h3C;

  oam_dma_arbiter dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rd(io_rd), .io_wr(io_wr), .io_rdata(io_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = ((cyc % tick_div) == 0);
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dma_active) act_cyc++;
        if (tick && dma_active) act_ticks++;
        if (tick && dma_active && bus_rd) begin
          rd_cnt++;
          vecs++;
          if (rdq.size() == 0) begin
            errs++;
            $display("FAIL dma_rd unexpected: addr=%h", bus_addr);
          end else begin
            e = rdq.pop_front();
            if (bus_addr !== e) begin
              errs++;
              $display("FAIL dma_rd addr: got %h want %h", bus_addr, e);
            end
          end
        end
        if (tick && oam_wr) begin
          wr_cnt++;
          oam_m[oam_addr] = oam_wdata;
          vecs++;
          if (oamq.size() == 0) begin
            errs++;
            $display("FAIL oam_wr unexpected: %h<=%h", oam_addr, oam_wdata);
          end else begin
            e = oamq.pop_front();
            if ({oam_addr, oam_wdata} !== e) begin
              errs++;
              $display("FAIL oam_wr: got %h<=%h want %h<=%h",
                       oam_addr, oam_wdata, e[15:8], e[7:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic push_xfer(input logic [7:0] page);
    for (int i = 0; i < 160; i++) begin
      rdq.push_back({page, 8'(i)});
      oamq.push_back({8'(i), mem_val({page, 8'(i)})});
    end
  endtask

  task automatic write_ff46(input logic [7:0] v);
    while (!tick) step();
    cpu_addr  = 16'hFF46;
    cpu_wdata = v;
    cpu_wr    = 1'b1;
    step();
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  task automatic start_dma(input logic [7:0] v, input logic [7:0] page);
    act_ticks = 0;
    act_cyc   = 0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    push_xfer(page);
    write_ff46(v);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dma_active && n < 2000) begin
      step();
      n++;
    end
    vecs++;
    if (dma_active) begin
      errs++;
      $display("FAIL %s timeout: dma_active still 1", tag);
    end
    vecs++;
    if (rdq.size() != 0 || oamq.size() != 0) begin
      errs++;
      $display("FAIL %s leftover: rdq=%0d oamq=%0d want 0",
               tag, rdq.size(), oamq.size());
    end
  endtask

  task automatic check_ff46(input logic [7:0] want, input string tag);
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    #1;
    vecs++;
    if (cpu_rdata !== want || io_rd !== 1'b0) begin
      errs++;
      $display("FAIL %s ff46: got %h io_rd=%b want %h io_rd=0",
               tag, cpu_rdata, io_rd, want);
    end
    cpu_rd   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic check_oam(input logic [7:0] page, input string tag);
    for (int i = 0; i < 160; i++) begin
      vecs++;
      if (oam_m[i] !== mem_val({page, 8'(i)})) begin
        errs++;
        $display("FAIL %s oam[%0d]: got %h want %h",
                 tag, i, oam_m[i], mem_val({page, 8'(i)}));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vecs++;
    if (dma_active !== 1'b0 || oam_wr !== 1'b0 || bus_rd !== 1'b0 ||
        bus_wr !== 1'b0 || bus_addr !== 16'h0 || io_rd !== 1'b0 ||
        io_wr !== 1'b0 || oam_addr !== 8'h0 || bus_wdata !== 8'h0) begin
      errs++;
      $display("FAIL reset outputs: act=%b oam_wr=%b brd=%b bwr=%b ba=%h",
               dma_active, oam_wr, bus_rd, bus_wr, bus_addr);
    end
    check_ff46(8'hFF, "reset");
    rst_n = 1'b1;
    step();
    check_ff46(8'hFF, "post_reset");
  endtask

  task automatic test_idle_pass();
    cpu_addr = 16'h4000;
    cpu_rd   = 1'b1;
    #1;
    vecs++;
    if (bus_rd !== 1'b1 || bus_addr !== 16'h4000 || cpu_rdata !== 8'hDB) begin
      errs++;
      $display("FAIL idle_rd: rd=%b a=%h d=%h want 1 4000 db",
               bus_rd, bus_addr, cpu_rdata);
    end
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 16'hC000;
    cpu_wdata = 8'h33;
    #1;
    vecs++;
    if (bus_wr !== 1'b1 || bus_rd !== 1'b0 || bus_addr !== 16'hC000 ||
        bus_wdata !== 8'h33) begin
      errs++;
      $display("FAIL idle_wr: wr=%b rd=%b a=%h d=%h want 1 0 c000 33",
               bus_wr, bus_rd, bus_addr, bus_wdata);
    end
    cpu_rd = 1'b1;
    #1;
    vecs++;
    if (bus_wr !== 1'b1 || bus_rd !== 1'b0) begin
      errs++;
      $display("FAIL rd_wr_prio: wr=%b rd=%b want 1 0", bus_wr, bus_rd);
    end
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_wdata = 8'h00;
    #1;
    vecs++;
    if (bus_wr !== 1'b0 || bus_rd !== 1'b0 || io_rd !== 1'b0 ||
        io_wr !== 1'b0) begin
      errs++;
      $display("FAIL no_strobe: bwr=%b brd=%b iord=%b iowr=%b want 0",
               bus_wr, bus_rd, io_rd, io_wr);
    end
    cpu_addr = 16'h0000;
    step();
  endtask

  task automatic test_basic();
    start_dma(8'hC1, 8'hC1);
    vecs++;
    if (dma_active !== 1'b1 || bus_rd !== 1'b0) begin
      errs++;
      $display("FAIL start: act=%b rd=%b want 1 0", dma_active, bus_rd);
    end
    step();
    vecs++;
    if (bus_rd !== 1'b1 || bus_addr !== 16'hC100 || oam_wr !== 1'b0) begin
      errs++;
      $display("FAIL first_rd: rd=%b a=%h ow=%b want 1 c100 0",
               bus_rd, bus_addr, oam_wr);
    end
    step();
    vecs++;
    if (oam_wr !== 1'b1 || oam_addr !== 8'h00 || oam_wdata !== 8'h5A) begin
      errs++;
      $display("FAIL first_wr: w=%b a=%h d=%h want 1 00 5a",
               oam_wr, oam_addr, oam_wdata);
    end
    for (int i = 0; i < 20; i++) step();
    cpu_addr = 16'h8000;
    cpu_rd   = 1'b1;
    #1;
    vecs++;
    if (cpu_rdata !== 8'hFF || bus_rd !== 1'b1 || bus_addr[15:8] !== 8'hC1) begin
      errs++;
      $display("FAIL blk_rd: d=%h rd=%b a=%h want ff 1 c1xx",
               cpu_rdata, bus_rd, bus_addr);
    end
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 16'hC000;
    cpu_wdata = 8'h77;
    #1;
    vecs++;
    if (bus_wr !== 1'b0 || bus_addr[15:8] !== 8'hC1) begin
      errs++;
      $display("FAIL blk_wr: wr=%b a=%h want 0 c1xx", bus_wr, bus_addr);
    end
    cpu_wr   = 1'b0;
    cpu_rd   = 1'b1;
    cpu_addr = 16'hFF80;
    #1;
    vecs++;
    if (io_rd !== 1'b1 || io_addr !== 8'h80 || cpu_rdata !== 8'hBC) begin
      errs++;
      $display("FAIL hi_rd: rd=%b a=%h d=%h want 1 80 bc",
               io_rd, io_addr, cpu_rdata);
    end
    cpu_rd    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    wait_done("basic");
    vecs++;
    if (act_ticks !== 162 || rd_cnt !== 160 || wr_cnt !== 160) begin
      errs++;
      $display("FAIL basic counts: ticks=%0d rd=%0d wr=%0d want 162 160 160",
               act_ticks, rd_cnt, wr_cnt);
    end
    for (int i = 0; i < 160; i++) begin
      vecs++;
      if (oam_m[i] !== (8'(i) ^ 8'h5A)) begin
        errs++;
        $display("FAIL basic oam[%0d]: got %h want %h",
                 i, oam_m[i], 8'(i) ^ 8'h5A);
      end
    end
    check_ff46(8'hC1, "basic");
  endtask

  task automatic test_echo();
    start_dma(8'hFE, 8'hDE);
    wait_done("echo_fe");
    start_dma(8'hE0, 8'hC0);
    wait_done("echo_e0");
    check_oam(8'hC0, "echo_e0");
    check_ff46(8'hE0, "echo");
  endtask

  task automatic test_restart();
    int n;
    start_dma(8'hC0, 8'hC0);
    n = 0;
    while (!(bus_rd && bus_addr == 16'hC032) && n < 300) begin
      step();
      n++;
    end
    vecs++;
    if (n >= 300) begin
      errs++;
      $display("FAIL restart seek: c032 never read");
    end
    write_ff46(8'hD0);
    rdq.delete();
    oamq.delete();
    push_xfer(8'hD0);
    wait_done("restart");
    vecs++;
    if (wr_cnt !== 210 || rd_cnt !== 211) begin
      errs++;
      $display("FAIL restart counts: wr=%0d rd=%0d want 210 211",
               wr_cnt, rd_cnt);
    end
    check_oam(8'hD0, "restart");
  endtask

  task automatic test_slow_tick();
    int n;
    tick_div = 3;
    start_dma(8'hC2, 8'hC2);
    wait_done("slow");
    vecs++;
    if (act_ticks !== 162 || act_cyc !== 486) begin
      errs++;
      $display("FAIL slow timing: ticks=%0d cyc=%0d want 162 486",
               act_ticks, act_cyc);
    end
    check_oam(8'hC2, "slow");
    start_dma(8'hC3, 8'hC3);
    n = 0;
    while (!(oam_wr && oam_addr == 8'd79) && n < 1000) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (dma_active !== 1'b0 || oam_wr !== 1'b0 || bus_rd !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: act=%b ow=%b rd=%b want 0 0 0",
               dma_active, oam_wr, bus_rd);
    end
    step();
    step();
    rst_n = 1'b1;
    rdq.delete();
    oamq.delete();
    n = wr_cnt;
    for (int i = 0; i < 20; i++) step();
    vecs++;
    if (wr_cnt !== n || dma_active !== 1'b0) begin
      errs++;
      $display("FAIL post_rst: wr=%0d act=%b want %0d 0",
               wr_cnt, dma_active, n);
    end
    check_ff46(8'hFF, "post_rst");
    tick_div = 1;
    step();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_idle_pass();
    test_basic();
    test_echo();
    test_restart();
    test_slow_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the SM83 external memory bus and shares it between the CPU core and the OAM DMA engine.
- Contains the DMA source register at 0xFF46.
- On a write to that register, copies 160 bytes from {src,8'h00}..{src,8'h9F} into OAM through a dedicated OAM write port, pipelined one byte per M-cycle.
- While DMA owns the bus, CPU accesses below 0xFF00 are blocked. High-page (0xFFxx) accesses always pass to the IO/HRAM port.

Parameters:
- OAM_LEN, 160, number of bytes per transfer; index width is 8 bits and OAM_LEN must be at most 255.
- BLOCK_RDATA, 8'hFF, value returned to CPU reads blocked during transfer.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  M-cycle enable; all state advances only on clk edges with tick=1
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rd  in  1  CPU read request
- cpu_wr  in  1  CPU write request
- cpu_rdata  out  8  CPU read data (combinational)
- bus_addr  out  16  external bus address
- bus_wdata  out  8  external bus write data
- bus_rd  out  1  external bus read strobe
- bus_wr  out  1  external bus write strobe
- bus_rdata  in  8  external bus read data, valid at tick
- io_addr  out  8  low byte of a 0xFFxx access
- io_wdata  out  8  IO/HRAM write data
- io_rd  out  1  IO/HRAM read strobe
- io_wr  out  1  IO/HRAM write strobe
- io_rdata  in  8  IO/HRAM read data
- oam_addr  out  8  OAM write index
- oam_wdata  out  8  OAM write data
- oam_wr  out  1  OAM write strobe
- dma_active  out  1  high in START and XFER

Behaviour:
- Reset:
  - state=IDLE, idx=0, data_q=0, dma_reg=8'hFF.
  - All strobes 0, addresses and data 0, dma_active 0.
  - Reset mid-transfer aborts immediately; no further OAM writes occur.
- States:
  - IDLE: no transfer in progress.
  - START: one tick of setup; the CPU still owns the bus.
  - XFER: idx runs 0..OAM_LEN, i.e. 161 ticks.
- Transitions:
  - Any state: cpu_wr && cpu_addr==16'hFF46 && tick -> dma_reg<=cpu_wdata, idx<=0, state<=START.
  - START and tick -> XFER.
  - XFER and tick: idx<=idx+1; when idx==OAM_LEN -> IDLE.
- Source address:
  - src_hi = dma_reg.
  - If dma_reg >= 8'hE0, src_hi = dma_reg - 8'h20 (echo mapping: E0->C0, FE->DE, FF->DF).
- XFER step idx:
  - If idx < OAM_LEN: bus_rd=1, bus_addr={src_hi,idx}; data_q<=bus_rdata at tick.
  - If idx >= 1: oam_wr=1, oam_addr=idx-1, oam_wdata=data_q.
  - Read of byte n and OAM write of byte n-1 overlap.
  - Total: 160 reads and 160 OAM writes; last OAM write at idx=160.
- CPU routing (combinational):
  - 0xFF46: never forwarded to the io_* port.
    - Reads return dma_reg.
    - Writes handled as above, in any state.
  - Other 0xFF00-0xFFFF: io_addr=cpu_addr[7:0], io_rd/io_wr/io_wdata follow the CPU; cpu_rdata=io_rdata. Unaffected by DMA.
  - Below 0xFF00, state != XFER: bus_* follow the CPU; cpu_rdata=bus_rdata.
  - Below 0xFF00, state == XFER:
    - CPU writes are dropped.
    - CPU reads return BLOCK_RDATA.
    - bus_* reflect the DMA only.
- Restart: a write to 0xFF46 during XFER drops the in-flight data_q byte (no OAM write for it), loads the new source and returns to START. OAM is not cleared.
- tick=0: no registered state changes. Outputs hold their combinational values.
- Simultaneous cpu_rd and cpu_wr: write takes precedence. Neither strobe asserted -> all CPU-derived strobes 0.
- Latency from the 0xFF46 write tick:
  - First bus read 2 ticks later (after the write tick and START).
  - First OAM write 3 ticks later.
  - dma_active falls after 162 ticks.

Decomposition:
- sm83_pkg additions:
  - DMA_REG_ADDR=16'hFF46, HIGH_PAGE=8'hFF.
  - OAM_DMA_LEN=160.
  - typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t.
- No sub-module: one sequential block plus a combinational router; the address decode is a local function.

Test Plan:
- Write 0xC1 to FF46 with tick every cycle, memory[C100+i]=i^8'h5A -> bus_rd addresses C100..C19F; OAM[i]=i^8'h5A for i=0..159; dma_active high for exactly 162 ticks; FF46 reads back C1.
- During XFER, CPU read 0x8000 -> cpu_rdata=FF and bus_addr stays the DMA address. CPU write 0xC000 -> no bus_wr. CPU read FF80 -> io_rd=1, io_addr=80, cpu_rdata=io_rdata.
- Write 0xFE to FF46 -> source reads DE00..DE9F. Write 0xE0 -> reads C000..C09F.
- Write 0xC0, then at idx=50 write 0xD0 -> no OAM write for C0 byte 50; next 161 XFER ticks read D000..D09F; OAM[0..159] end equal to D0xx data.
- tick asserted every 3rd cycle -> same final OAM contents and state advances only on tick edges. Assert rst_n=0 at idx=80 -> dma_active=0, oam_wr=0 immediately; FF46 reads FF.
- Idle CPU read 0x4000 and write 0xC000=8'h33 -> bus passthrough, cpu_rdata=bus_rdata, bus_wr=1 with wdata 33.
